// File: rtl/rgb_pkg.sv
// Shared encodings and helpers for the multi-channel PWM LED driver.
package rgb_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;

    typedef enum logic {
        BR_UP   = 1'b0,
        BR_DOWN = 1'b1
    } br_st_e;

    typedef enum logic {
        BL_ON  = 1'b0,
        BL_OFF = 1'b1
    } bl_st_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb_pwm_drv_if.sv
// Host write port of the PWM LED driver: valid/ready channel write plus error pulse.
interface rgb_pwm_drv_if #(
    parameter int NCH = 3,
    parameter int PW  = 8
);
    import rgb_pkg::*;

    localparam int CHW = cnt_w(NCH);

    logic           wr_vld;
    logic           wr_rdy;
    logic [CHW-1:0] wr_ch;
    mode_e          wr_mode;
    logic [PW-1:0]  wr_lvl;
    logic           wr_err;

    modport master (
        output wr_vld, wr_ch, wr_mode, wr_lvl,
        input  wr_rdy, wr_err
    );

    modport slave (
        input  wr_vld, wr_ch, wr_mode, wr_lvl,
        output wr_rdy, wr_err
    );

endinterface

// File: rtl/rgb_pwm_chan.sv
// One LED channel: shadow/active mode, breathe and blink sequencers, duty compare and output flop.
module rgb_pwm_chan
    import rgb_pkg::*;
#(
    parameter int PW        = 8,
    parameter int STEP_DIV  = 4,
    parameter int BLINK_PER = 64,
    parameter int ACT_LOW   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  mode_e         wr_mode,
    input  logic [PW-1:0] wr_lvl,
    input  logic          bnd,
    input  logic [PW-1:0] pwm_cnt,
    output logic          led
);

    localparam int            SW        = cnt_w(STEP_DIV);
    localparam int            BW        = cnt_w(BLINK_PER);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [BW-1:0] BL_LAST   = BW'(BLINK_PER - 1);
    localparam logic [PW-1:0] PW_MAX    = {PW{1'b1}};
    localparam logic          ACT_LOW_B = (ACT_LOW != 0);

    mode_e         sh_mode_r;
    logic [PW-1:0] sh_lvl_r;
    mode_e         act_mode_r;
    logic [PW-1:0] duty_r;
    logic [SW-1:0] step_cnt_r;
    logic [BW-1:0] blink_cnt_r;
    br_st_e        br_st_r;
    bl_st_e        bl_st_r;
    logic          led_r;
    logic [PW-1:0] duty_inc_s;
    logic [PW-1:0] duty_dec_s;

    // Saturating neighbours of the current duty for the breathe ramp.
    always_comb begin
        duty_inc_s = (duty_r == PW_MAX) ? duty_r : duty_r + PW'(1);
        duty_dec_s = (duty_r == '0)     ? duty_r : duty_r - PW'(1);
    end

    // Shadow capture, boundary-aligned duty sequencing and registered LED compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_mode_r   <= MODE_OFF;
            sh_lvl_r    <= '0;
            act_mode_r  <= MODE_OFF;
            duty_r      <= '0;
            step_cnt_r  <= '0;
            blink_cnt_r <= '0;
            br_st_r     <= BR_UP;
            bl_st_r     <= BL_ON;
            led_r       <= ACT_LOW_B;
        end else begin
            if (wr_en) begin
                sh_mode_r <= wr_mode;
                sh_lvl_r  <= wr_lvl;
            end
            led_r <= (pwm_cnt < duty_r) ^ ACT_LOW_B;
            // Boundary sees the shadow as it was before any same-cycle write.
            if (bnd) begin
                act_mode_r <= sh_mode_r;
                if (sh_mode_r != act_mode_r) begin
                    step_cnt_r  <= '0;
                    blink_cnt_r <= '0;
                    br_st_r     <= BR_UP;
                    bl_st_r     <= BL_ON;
                    case (sh_mode_r)
                        MODE_STATIC, MODE_BLINK: duty_r <= sh_lvl_r;
                        default:                 duty_r <= '0;
                    endcase
                end else begin
                    case (sh_mode_r)
                        MODE_STATIC: duty_r <= sh_lvl_r;
                        MODE_BREATHE: begin
                            if (sh_lvl_r == '0) begin
                                duty_r     <= '0;
                                br_st_r    <= BR_UP;
                                step_cnt_r <= '0;
                            end else if (step_cnt_r == STEP_LAST) begin
                                step_cnt_r <= '0;
                                case (br_st_r)
                                    BR_UP: begin
                                        duty_r  <= duty_inc_s;
                                        br_st_r <= (duty_inc_s >= sh_lvl_r) ? BR_DOWN : BR_UP;
                                    end
                                    BR_DOWN: begin
                                        duty_r  <= duty_dec_s;
                                        br_st_r <= (duty_dec_s == '0) ? BR_UP : BR_DOWN;
                                    end
                                    default: begin
                                        duty_r  <= '0;
                                        br_st_r <= BR_UP;
                                    end
                                endcase
                            end else begin
                                step_cnt_r <= step_cnt_r + SW'(1);
                            end
                        end
                        MODE_BLINK: begin
                            if (blink_cnt_r == BL_LAST) begin
                                blink_cnt_r <= '0;
                                bl_st_r     <= (bl_st_r == BL_ON) ? BL_OFF : BL_ON;
                                duty_r      <= (bl_st_r == BL_ON) ? '0 : sh_lvl_r;
                            end else begin
                                blink_cnt_r <= blink_cnt_r + BW'(1);
                                duty_r      <= (bl_st_r == BL_ON) ? sh_lvl_r : '0;
                            end
                        end
                        default: duty_r <= '0;
                    endcase
                end
            end
        end
    end

    assign led = led_r;

endmodule

// File: rtl/rgb_pwm_drv.sv
// Multi-channel PWM LED driver: write port, shared prescaler/PWM timebase, one channel per LED.
module rgb_pwm_drv
    import rgb_pkg::*;
#(
    parameter int NCH       = 3,
    parameter int PW        = 8,
    parameter int PRESCALE  = 256,
    parameter int STEP_DIV  = 4,
    parameter int BLINK_PER = 64,
    parameter int ACT_LOW   = 1
) (
    input  logic           clk,
    input  logic           rst,
    rgb_pwm_drv_if.slave   wr,
    output logic           prd_stb,
    output logic [NCH-1:0] led
);

    localparam int              CHW      = cnt_w(NCH);
    localparam int              PREW     = cnt_w(PRESCALE);
    localparam logic [PREW-1:0] PRE_LAST = PREW'(PRESCALE - 1);
    localparam logic [PW-1:0]   PW_MAX   = {PW{1'b1}};

    logic [PREW-1:0] pre_cnt_r;
    logic [PREW-1:0] pre_nxt_s;
    logic [PW-1:0]   pwm_cnt_r;
    logic [PW-1:0]   pwm_nxt_s;
    logic            prd_stb_r;
    logic            prd_nxt_s;
    logic            rdy_r;
    logic            err_r;
    logic            wr_acc_s;
    logic [NCH-1:0]  wr_en_s;

    // Next timebase state; prd_stb is looked ahead one cycle so it can leave a flop.
    always_comb begin
        if (pre_cnt_r == PRE_LAST) begin
            pre_nxt_s = '0;
            pwm_nxt_s = pwm_cnt_r + PW'(1);
        end else begin
            pre_nxt_s = pre_cnt_r + PREW'(1);
            pwm_nxt_s = pwm_cnt_r;
        end
        prd_nxt_s = (pre_nxt_s == PRE_LAST) && (pwm_nxt_s == PW_MAX);
    end

    // Write accept and per-channel enable decode.
    always_comb begin
        wr_acc_s = wr.wr_vld & rdy_r;
        wr_en_s  = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_en_s[i] = wr_acc_s && (wr.wr_ch == CHW'(i));
        end
    end

    // Timebase, ready and error flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_r <= '0;
            pwm_cnt_r <= '0;
            prd_stb_r <= 1'b0;
            rdy_r     <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            pre_cnt_r <= pre_nxt_s;
            pwm_cnt_r <= pwm_nxt_s;
            prd_stb_r <= prd_nxt_s;
            rdy_r     <= 1'b1;
            err_r     <= wr_acc_s && ({1'b0, wr.wr_ch} >= (CHW + 1)'(NCH));
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        rgb_pwm_chan #(
            .PW        (PW),
            .STEP_DIV  (STEP_DIV),
            .BLINK_PER (BLINK_PER),
            .ACT_LOW   (ACT_LOW)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en_s[i]),
            .wr_mode (wr.wr_mode),
            .wr_lvl  (wr.wr_lvl),
            .bnd     (prd_stb_r),
            .pwm_cnt (pwm_cnt_r),
            .led     (led[i])
        );
    end

    assign wr.wr_rdy = rdy_r;
    assign wr.wr_err = err_r;
    assign prd_stb   = prd_stb_r;

endmodule

// File: tb/tb_rgb_pwm_drv.sv
// Directed bench for rgb_pwm_drv: one table row per PWM period with expected per-channel duties.
module tb_rgb_pwm_drv;
    import rgb_pkg::*;

    localparam int NW = -9;

    typedef struct packed {
        int         wa_at;
        logic [1:0] wa_ch;
        mode_e      wa_mode;
        logic [3:0] wa_lvl;
        int         wb_at;
        logic [1:0] wb_ch;
        mode_e      wb_mode;
        logic [3:0] wb_lvl;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        int         err_at;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       prd_stb;
    logic [2:0] led;
    int         n_pass;
    int         n_total;
    vec_t       tbl [24];

    rgb_pwm_drv_if #(.NCH(3), .PW(4)) wr_bus ();

    rgb_pwm_drv #(
        .NCH(3), .PW(4), .PRESCALE(1), .STEP_DIV(1), .BLINK_PER(2), .ACT_LOW(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr_bus.slave),
        .prd_stb (prd_stb),
        .led     (led)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int wa_at, input logic [1:0] wa_ch, input mode_e wa_mode,
                                input logic [3:0] wa_lvl, input int wb_at, input logic [1:0] wb_ch,
                                input mode_e wb_mode, input logic [3:0] wb_lvl, input logic [3:0] d0,
                                input logic [3:0] d1, input logic [3:0] d2, input int err_at);
        vec_t v;
        v.wa_at = wa_at; v.wa_ch = wa_ch; v.wa_mode = wa_mode; v.wa_lvl = wa_lvl;
        v.wb_at = wb_at; v.wb_ch = wb_ch; v.wb_mode = wb_mode; v.wb_lvl = wb_lvl;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.err_at = err_at;
        return v;
    endfunction

    // Active-low LED pattern over one period: sample k is low while k < duty.
    function automatic logic [15:0] exp_led(input logic [3:0] d);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[k] = (k < int'(d)) ? 1'b0 : 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic [1:0] ch, input mode_e m, input logic [3:0] l);
        wr_bus.wr_vld  = 1'b1;
        wr_bus.wr_ch   = ch;
        wr_bus.wr_mode = m;
        wr_bus.wr_lvl  = l;
    endtask

    // Samples 16 negedges (reflecting pwm_cnt 0..15 of one period) and issues the row's writes.
    task automatic run_period(input int p, input vec_t v);
        logic [15:0] obs0, obs1, obs2, stb, err, eerr;
        if (v.wa_at == -1) drive(v.wa_ch, v.wa_mode, v.wa_lvl);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            obs0[k] = led[0];
            obs1[k] = led[1];
            obs2[k] = led[2];
            stb[k]  = prd_stb;
            err[k]  = wr_bus.wr_err;
            wr_bus.wr_vld = 1'b0;
            if (k == v.wa_at) drive(v.wa_ch, v.wa_mode, v.wa_lvl);
            if (k == v.wb_at) drive(v.wb_ch, v.wb_mode, v.wb_lvl);
        end
        eerr = (v.err_at >= 0) ? (16'd1 << v.err_at) : 16'd0;
        chk($sformatf("p%0d_led0", p), obs0, exp_led(v.d0));
        chk($sformatf("p%0d_led1", p), obs1, exp_led(v.d1));
        chk($sformatf("p%0d_led2", p), obs2, exp_led(v.d2));
        chk($sformatf("p%0d_prd_stb", p), stb, 16'h4000);
        chk($sformatf("p%0d_wr_err", p), err, eerr);
    endtask

    initial begin
        logic found;
        logic bad;
        int   stb_idx;
        clk = 1'b0; rst = 1'b1; n_pass = 0; n_total = 0;
        wr_bus.wr_vld = 1'b0; wr_bus.wr_ch = 2'd0; wr_bus.wr_mode = MODE_OFF; wr_bus.wr_lvl = 4'd0;

        //                wa  ch   mode          lvl    wb  ch   mode         lvl    d0    d1     d2   err
        tbl[0]  = mk(    3, 2'd0, MODE_STATIC,  4'd5,  NW, 2'd0, MODE_OFF,    4'd0,  4'd5 - 4'd5, 4'd0, 4'd0, -1);
        tbl[1]  = mk(   -1, 2'd1, MODE_STATIC,  4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd5,  4'd0,  4'd0, -1);
        tbl[2]  = mk(    5, 2'd1, MODE_STATIC,  4'd15, NW, 2'd0, MODE_OFF,    4'd0,  4'd5,  4'd0,  4'd0, -1);
        tbl[3]  = mk(    2, 2'd2, MODE_BREATHE, 4'd3,  NW, 2'd0, MODE_OFF,    4'd0,  4'd5,  4'd15, 4'd0, -1);
        tbl[4]  = mk(   NW, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd5,  4'd15, 4'd0, -1);
        tbl[5]  = mk(   NW, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd5,  4'd15, 4'd1, -1);
        tbl[6]  = mk(   NW, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd5,  4'd15, 4'd2, -1);
        tbl[7]  = mk(   NW, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd5,  4'd15, 4'd3, -1);
        tbl[8]  = mk(   NW, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd5,  4'd15, 4'd2, -1);
        tbl[9]  = mk(   NW, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd5,  4'd15, 4'd1, -1);
        tbl[10] = mk(   NW, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd5,  4'd15, 4'd0, -1);
        tbl[11] = mk(    4, 2'd2, MODE_BREATHE, 4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd5,  4'd15, 4'd1, -1);
        tbl[12] = mk(    1, 2'd1, MODE_STATIC,  4'd9,   6, 2'd1, MODE_STATIC, 4'd7,  4'd5,  4'd15, 4'd0, -1);
        tbl[13] = mk(    0, 2'd0, MODE_BLINK,   4'd8,  NW, 2'd0, MODE_OFF,    4'd0,  4'd5,  4'd7,  4'd0, -1);
        tbl[14] = mk(   NW, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd8,  4'd7,  4'd0, -1);
        tbl[15] = mk(   NW, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd8,  4'd7,  4'd0, -1);
        tbl[16] = mk(   NW, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd0,  4'd7,  4'd0, -1);
        tbl[17] = mk(   NW, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd0,  4'd7,  4'd0, -1);
        tbl[18] = mk(   NW, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd8,  4'd7,  4'd0, -1);
        tbl[19] = mk(    3, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd8,  4'd7,  4'd0, -1);
        tbl[20] = mk(    2, 2'd3, MODE_STATIC,  4'd12, NW, 2'd0, MODE_OFF,    4'd0,  4'd0,  4'd7,  4'd0,  3);
        tbl[21] = mk(   14, 2'd1, MODE_STATIC,  4'd3,  NW, 2'd0, MODE_OFF,    4'd0,  4'd0,  4'd7,  4'd0, -1);
        tbl[22] = mk(   NW, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd0,  4'd7,  4'd0, -1);
        tbl[23] = mk(   NW, 2'd0, MODE_OFF,     4'd0,  NW, 2'd0, MODE_OFF,    4'd0,  4'd0,  4'd3,  4'd0, -1);

        // Power-on reset held for three edges.
        repeat (3) @(negedge clk);
        chk("rst_led", 16'(led), 16'h0007);
        chk("rst_rdy", 16'(wr_bus.wr_rdy), 16'h0000);
        chk("rst_prd_stb", 16'(prd_stb), 16'h0000);
        chk("rst_wr_err", 16'(wr_bus.wr_err), 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", 16'(wr_bus.wr_rdy), 16'h0001);
        chk("led_after_rst", 16'(led), 16'h0007);

        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (prd_stb) found = 1'b1;
        end
        chk("first_prd_stb", 16'(found), 16'h0001);
        @(negedge clk);

        for (int p = 0; p < 24; p++) run_period(p, tbl[p]);

        // Reset in the middle of a period while ch1 is lit.
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_led", 16'(led), 16'h0007);
        chk("midrst_rdy", 16'(wr_bus.wr_rdy), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        stb_idx = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (led !== 3'b111) bad = 1'b1;
            if (prd_stb === 1'b1 && stb_idx < 0) stb_idx = n;
        end
        chk("postrst_led_idle", 16'(bad), 16'h0000);
        chk("postrst_stb_pos", 16'(stb_idx), 16'd15);
        chk("postrst_rdy", 16'(wr_bus.wr_rdy), 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
